timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
Control sequencer for the timer datapath: owns the down-counter register bank built from the team's flip-flop cells and sequences it through load, count, pause, expire and reload. A programmable prescaler generates the count enable. The block supports one-shot and periodic modes and raises a sticky expiry flag for the interrupt logic. It sits between the host configuration interface and the counter/interrupt path of the timer.

Parameters:
WIDTH, 16, counter and reload-value width in bits
PSC_W, 8, prescaler divide-value width in bits

Ports:
clk  input  1  single system clock, rising edge
clr  input  1  asynchronous active-high reset
cfg_we  input  1  write strobe for the shadow config registers
cfg_load  input  WIDTH  reload value, captured on cfg_we
cfg_psc  input  PSC_W  prescale value P, captured on cfg_we; count enable fires every P+1 clocks
cfg_periodic  input  1  0 = one-shot, 1 = periodic; captured on cfg_we
start  input  1  start from IDLE/DONE (with reload), or resume from PAUSE
stop  input  1  pause from RUN; abort to IDLE from PAUSE
irq_ack  input  1  clears expired
count  output  WIDTH  current counter value
tick  output  1  one-cycle prescaler pulse; counter decrements on this cycle
running  output  1  high in RUN
expired  output  1  sticky expiry flag (interrupt request)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (clr). Every register responds to clr immediately, not at the next edge.
- Reset values: state=IDLE, count=0, psc_cnt=0, tick=0, running=0, expired=0. Shadow registers: load=0, psc=0, periodic=0.
- Shadow config: on cfg_we, load/psc/periodic update at the next edge in any state.
  - A running count is not disturbed.
  - A new load value takes effect at the next reload.
  - A new psc value takes effect at the next prescaler wrap.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN).
- IDLE:
  - start with load!=0 -> RUN; count<=load, psc_cnt<=0.
  - start with load==0 -> ignored, stay IDLE.
- RUN:
  - psc_cnt increments each cycle. When psc_cnt==psc: tick=1 for that cycle, psc_cnt<=0, count<=count-1.
  - Expiry is a tick with count==1. count reaches 0 and expired<=1, then:
    - one-shot: -> DONE, count holds 0.
    - periodic: count<=load in the same edge (never shows 0), stay RUN.
    - If load==0 at a periodic reload: -> DONE.
  - stop -> PAUSE. count and psc_cnt are held, and no tick occurs on the stop cycle.
- PAUSE:
  - start -> RUN, resuming without reload or psc_cnt reset.
  - stop -> IDLE, count<=0.
- DONE:
  - start with load!=0 -> RUN with reload, as from IDLE.
  - stop -> IDLE.
- Simultaneous events:
  - start and stop in the same cycle: stop wins in all states.
  - irq_ack in the same cycle as an expiry: expired stays 1 (set wins).
  - cfg_we in the same cycle as a reload: the reload uses the old shadow load.
- Latency: start sampled at edge N -> running=1 and count=load after edge N. First tick is psc+1 cycles later. Expiry of load L takes L*(psc+1) cycles from start.
- Arithmetic: unsigned. count never decrements below 0 or wraps, and tick is only generated in RUN.
- Reset mid-operation: clr in any state forces all reset values asynchronously. On release, the block is in IDLE and requires a fresh start.

Test Plan:
1. Reset mid-count: cfg load=10, psc=0, start; assert clr at count=6 -> count=0, running=0, expired=0 immediately; after release a start reloads 10.
2. One-shot: load=5, psc=0, periodic=0, start -> count 5,4,3,2,1,0 on consecutive cycles; expired=1 on the 0 cycle; state DONE; count holds 0 for 20 cycles.
3. Periodic with prescale: load=3, psc=2, periodic=1 -> tick every 3rd cycle; count sequence 3,2,1,3,2,1; expired rises after 9 cycles; irq_ack clears it; it re-sets at 18 cycles.
4. Pause/resume: load=8, psc=1; stop at count=5 for 7 cycles -> count frozen at 5, tick=0; start resumes and reaches 0 exactly 10 running cycles later. Then stop twice -> IDLE, count=0.
5. Corner events: start with load=0 -> stays IDLE. start+stop together in IDLE -> stays IDLE. irq_ack on the expiry cycle -> expired=1. cfg_we load=7 on a periodic reload cycle -> reload uses the old value; the next period uses 7.
6. Live reconfig: in RUN with load=4, write psc=3 -> current prescale interval completes at the old rate; subsequent ticks every 4 cycles; count is undisturbed by the write.

Source files
------------

// File: rtl/timer_ctrl.sv
// Timer control sequencer: shadow config, prescaled down-counter and a
// one-shot/periodic run FSM with a sticky expiry flag.
module timer_ctrl #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [PSC_W-1:0] cfg_psc,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [PSC_W-1:0] psc_act_q, psc_act_d;
  logic             periodic_q, periodic_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             tick_w;
  logic             expire_w;

  always_comb begin
    // psc_act holds the divide value of the interval in progress, so a new
    // shadow psc only applies from the next prescaler wrap.
    tick_w     = (state_q == RUN) && !stop && (psc_cnt_q == psc_act_q);
    expire_w   = tick_w && (count_q == WIDTH'(1));

    state_d    = state_q;
    count_d    = count_q;
    psc_cnt_d  = psc_cnt_q;
    psc_act_d  = psc_act_q;
    load_d     = load_q;
    psc_d      = psc_q;
    periodic_d = periodic_q;
    expired_d  = expired_q;

    if (cfg_we) begin
      load_d     = cfg_load;
      psc_d      = cfg_psc;
      periodic_d = cfg_periodic;
    end

    if (expire_w) begin
      expired_d = 1'b1;
    end else if (irq_ack) begin
      expired_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start && (load_q != '0)) begin
          state_d   = RUN;
          count_d   = load_q;
          psc_cnt_d = '0;
          psc_act_d = psc_q;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (tick_w) begin
          psc_cnt_d = '0;
          psc_act_d = psc_q;
          if (expire_w) begin
            // Reload uses the shadow value as it stood before this edge.
            if (periodic_q && (load_q != '0)) begin
              count_d = load_q;
            end else begin
              state_d = DONE;
              count_d = '0;
            end
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end
        end else begin
          psc_cnt_d = psc_cnt_q + PSC_W'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d   = IDLE;
          count_d   = '0;
          psc_cnt_d = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      count_q    <= '0;
      psc_cnt_q  <= '0;
      psc_act_q  <= '0;
      load_q     <= '0;
      psc_q      <= '0;
      periodic_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      psc_cnt_q  <= psc_cnt_d;
      psc_act_q  <= psc_act_d;
      load_q     <= load_d;
      psc_q      <= psc_d;
      periodic_q <= periodic_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_w;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected per-cycle outputs go through a
// scoreboard queue and are checked with immediate assertions.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_load = '0;
  logic [7:0]  cfg_psc = '0;
  logic        cfg_periodic = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        irq_ack = 1'b0;
  logic [15:0] count_o;
  logic        tick_o;
  logic        running_o;
  logic        expired_o;

  int test_cnt = 0;
  int fail_cnt = 0;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        run;
    logic        exp;
    logic        tk;
  } exp_t;

  exp_t sb[$];

  timer_ctrl #(.WIDTH(16), .PSC_W(8)) dut (
    .clk          (clk),
    .clr          (clr),
    .cfg_we       (cfg_we),
    .cfg_load     (cfg_load),
    .cfg_psc      (cfg_psc),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .irq_ack      (irq_ack),
    .count        (count_o),
    .tick         (tick_o),
    .running      (running_o),
    .expired      (expired_o)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input bit r, input bit e, input bit t);
    exp_t it;
    sb.push_back('{tag: tag, cnt: 16'(c), run: r, exp: e, tk: t});
    #1;
    it = sb.pop_front();
    test_cnt++;
    assert (count_o === it.cnt) else begin
      fail_cnt++;
      $error("FAIL %s count: observed %0d expected %0d", it.tag, count_o, it.cnt);
    end
    test_cnt++;
    assert (running_o === it.run) else begin
      fail_cnt++;
      $error("FAIL %s running: observed %0b expected %0b", it.tag, running_o, it.run);
    end
    test_cnt++;
    assert (expired_o === it.exp) else begin
      fail_cnt++;
      $error("FAIL %s expired: observed %0b expected %0b", it.tag, expired_o, it.exp);
    end
    test_cnt++;
    assert (tick_o === it.tk) else begin
      fail_cnt++;
      $error("FAIL %s tick: observed %0b expected %0b", it.tag, tick_o, it.tk);
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    chk("reset", 0, 0, 0, 0);
    clk1();
    clr = 1'b0;
    clk1();
  endtask

  task automatic do_cfg(input int l, input int p, input bit per);
    cfg_load     = 16'(l);
    cfg_psc      = 8'(p);
    cfg_periodic = per;
    cfg_we       = 1'b1;
    clk1();
    cfg_we       = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_e;
    bit exp_e;
    bit tk_e;
    int k;

    // Reset values, then reset mid-count.
    chk("por", 0, 0, 0, 0);
    clk1();
    clr = 1'b0;
    clk1();
    do_cfg(10, 0, 0);
    start = 1'b1;
    chk("t1_idle", 0, 0, 0, 0);
    clk1();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_run", 10 - i, 1, 0, 1);
      clk1();
    end
    chk("t1_at6", 6, 1, 0, 1);
    clr = 1'b1;
    chk("t1_clr_async", 0, 0, 0, 0);
    clk1();
    clr = 1'b0;
    start = 1'b1;
    chk("t1_shadow_cleared", 0, 0, 0, 0);
    clk1();
    start = 1'b0;
    chk("t1_start_ignored", 0, 0, 0, 0);
    do_cfg(10, 0, 0);
    do_start();
    chk("t1_reload", 10, 1, 0, 1);
    stop = 1'b1;
    chk("t1_stop_no_tick", 10, 1, 0, 0);
    clk1();
    chk("t1_pause", 10, 0, 0, 0);
    clk1();
    stop = 1'b0;
    chk("t1_abort_idle", 0, 0, 0, 0);

    // One-shot.
    do_reset();
    do_cfg(5, 0, 0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      chk("t2_count", 5 - i, 1, 0, 1);
      clk1();
    end
    for (int i = 0; i < 20; i++) begin
      chk("t2_done_hold", 0, 0, 1, 0);
      clk1();
    end
    irq_ack = 1'b1;
    clk1();
    irq_ack = 1'b0;
    chk("t2_ack", 0, 0, 0, 0);
    do_start();
    chk("t2_restart_done", 5, 1, 0, 1);

    // Periodic with prescale.
    do_reset();
    do_cfg(3, 2, 1);
    do_start();
    for (int c = 0; c <= 20; c++) begin
      irq_ack = (c == 10);
      exp_e = ((c >= 9) && (c <= 10)) || (c >= 18);
      chk("t3_periodic", 3 - ((c / 3) % 3), 1, exp_e, (c % 3) == 2);
      clk1();
    end
    irq_ack = 1'b0;

    // Pause and resume.
    do_reset();
    do_cfg(8, 1, 0);
    do_start();
    for (int c = 0; c < 6; c++) begin
      chk("t4_run", 8 - c / 2, 1, 0, (c % 2) == 1);
      clk1();
    end
    stop = 1'b1;
    chk("t4_stop", 5, 1, 0, 0);
    clk1();
    stop = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("t4_frozen", 5, 0, 0, 0);
      clk1();
    end
    start = 1'b1;
    chk("t4_resume_cycle", 5, 0, 0, 0);
    clk1();
    start = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk("t4_resumed", 5 - r / 2, 1, 0, (r % 2) == 1);
      clk1();
    end
    chk("t4_zero", 0, 0, 1, 0);
    do_start();
    chk("t4_rerun", 8, 1, 1, 0);
    clk1();
    stop = 1'b1;
    chk("t4_stop_on_tick", 8, 1, 1, 0);
    clk1();
    chk("t4_paused", 8, 0, 1, 0);
    clk1();
    stop = 1'b0;
    chk("t4_idle", 0, 0, 1, 0);

    // Corner events.
    do_reset();
    start = 1'b1;
    chk("t5_load0_start", 0, 0, 0, 0);
    clk1();
    start = 1'b0;
    chk("t5_load0_idle", 0, 0, 0, 0);
    do_cfg(4, 0, 1);
    start = 1'b1;
    stop  = 1'b1;
    chk("t5_start_stop", 0, 0, 0, 0);
    clk1();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_stop_wins", 0, 0, 0, 0);
    do_start();
    cfg_load = 16'd7;
    for (int c = 0; c <= 14; c++) begin
      irq_ack = (c == 3);
      cfg_we  = (c == 3);
      if (c < 4) cnt_e = 4 - c;
      else if (c < 8) cnt_e = 8 - c;
      else cnt_e = 15 - c;
      chk("t5_reload_cfg", cnt_e, 1, c >= 4, 1);
      clk1();
    end
    irq_ack = 1'b0;
    cfg_we  = 1'b0;

    // Live prescale reconfiguration.
    do_reset();
    do_cfg(4, 1, 1);
    do_start();
    cfg_psc = 8'd3;
    for (int c = 0; c <= 13; c++) begin
      cfg_we = (c == 2);
      if (c < 2) begin
        cnt_e = 4;
        tk_e  = (c == 1);
      end else if (c < 4) begin
        cnt_e = 3;
        tk_e  = (c == 3);
      end else begin
        k     = c - 4;
        cnt_e = (k < 4) ? 2 : ((k < 8) ? 1 : 4);
        tk_e  = (k % 4) == 3;
      end
      chk("t6_reconfig", cnt_e, 1, c >= 12, tk_e);
      clk1();
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
